// File: rtl/md_pkg.sv
// md_pkg: shared opcodes, FSM states, default latencies and helpers for the multiply/divide scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional build macro used by md_sched: MD_SCHED_CANCEL_EN.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W_DEF       = 4;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/div datapath producing the {hi,lo} result of one md op.
// Latency: 0 cycles (pure combinational), operands come from md_sched's latched copies.
// Backpressure: none; res_vld=0 for divide-by-zero so the caller leaves HI/LO untouched.
// Ports: op/a/b in (op, rs, rt); res_hi/res_lo out (result); res_vld out (result may be committed).
module md_arith
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_vld
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn_div;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] dvs_nz;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // One unsigned divider serves both DIV and DIVU: signed division runs
    // on magnitudes and the signs are reapplied afterwards. The magnitude of
    // 0x80000000 is 0x80000000 as an unsigned value, so the overflow case
    // (0x80000000 / -1) falls out naturally as quotient 0x80000000, remainder 0.
    assign sgn_div = (op == MD_DIV);
    assign dvd     = (sgn_div && a[31]) ? -a : a;
    assign dvs     = (sgn_div && b[31]) ? -b : b;
    // Keep the divider input defined on rt==0; the result is discarded anyway.
    assign dvs_nz  = (dvs == 32'd0) ? 32'd1 : dvs;
    assign quo     = dvd / dvs_nz;
    assign rem     = dvd % dvs_nz;

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_vld = 1'b0;
        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_vld          = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_vld          = 1'b1;
            end
            MD_DIV: begin
                res_lo  = (a[31] ^ b[31]) ? -quo : quo;
                res_hi  = a[31] ? -rem : rem;
                res_vld = (b != 32'd0);
            end
            MD_DIVU: begin
                res_lo  = quo;
                res_hi  = rem;
                res_vld = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO; models mult/div latency with a countdown.
// Latency: MTHI/MTLO commit at the issue edge; mult/div commit MULT_CYCLES/DIV_CYCLES edges after issue.
// Backpressure: busy (registered) and md_stall (busy | start of a mult/div) hold md instructions in D.
// Ports: clk, reset (sync, active-high), start/md_op/rs_val/rt_val from E; hi/lo/busy/md_stall out.
// Build option: MD_SCHED_CANCEL_EN adds input cancel to squash a start or abandon an op in flight.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int CNT_W       = MD_CNT_W_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
`ifdef MD_SCHED_CANCEL_EN
    input  logic        cancel,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e      op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        cancel_w;
    logic        start_ok;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_vld;

`ifdef MD_SCHED_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // A start that coincides with an exception squash must leave no trace.
    assign start_ok = start & ~cancel_w;

    md_arith u_arith (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .res_vld (res_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (is_muldiv(md_op)) begin
                        op_d    = md_op_e'(md_op);
                        a_d     = rs_val;
                        b_d     = rt_val;
                        cnt_d   = is_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d = ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_RUN: begin
                // start is never presented here (the stall unit holds it in D).
                if (cancel_w) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (res_vld) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == ST_RUN);
    assign md_stall = busy | (start & is_muldiv(md_op));

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched; directed vectors followed by randomized traffic.
// Latency: expected HI/LO values are queued with the edge at which they must appear.
// Backpressure: the driver only issues when its model says the unit is free (as the stall unit would).
module tb_md_sched;
    import md_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;
`ifdef MD_SCHED_CANCEL_EN
    logic        cancel = 1'b0;
`endif

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(NM), .DIV_CYCLES(ND), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
`ifdef MD_SCHED_CANCEL_EN
        .cancel   (cancel),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        scb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    // Model: latest scheduled HI/LO, pre-op copy, busy window [busy_start, busy_end).
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    int          busy_start = 0, busy_end = 0;
    // Values the DUT must currently be showing.
    logic [31:0] c_hi = 32'd0, c_lo = 32'd0;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural rules.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] h, input logic [31:0] l);
        longint          sa, sbv, q, r;
        longint unsigned ua, ub, uq, ur;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            MD_MULT:  return 64'(sa * sbv);
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return {h, l};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {h, l};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            MD_MTHI:  return {a, l};
            MD_MTLO:  return {h, a};
            default:  return {h, l};
        endcase
    endfunction

    function automatic logic [31:0] noise();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        start  = 1'b0;
        md_op  = 3'($urandom_range(0, 6));
        rs_val = noise();
        rt_val = noise();
        step();
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) idle_step();
    endtask

    // Called right after an edge; the op is taken at the next edge t.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit cxl);
        int          t;
        logic [63:0] r;
        exp_t        e;
        t      = cyc + 1;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
`ifdef MD_SCHED_CANCEL_EN
        cancel = cxl;
`endif
        if (!cxl && op != MD_NONE) begin
            r    = ref_md(op, a, b, m_hi, m_lo);
            p_hi = m_hi;
            p_lo = m_lo;
            e.due = t;
            if (op == MD_MULT || op == MD_MULTU) e.due = t + NM;
            if (op == MD_DIV || op == MD_DIVU) e.due = t + ND;
            if (e.due != t) begin
                busy_start = t;
                busy_end   = e.due;
            end
            e.hi = r[63:32];
            e.lo = r[31:0];
            scb.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        step();
        start  = 1'b0;
        md_op  = 3'($urandom_range(0, 6));
        rs_val = noise();
        rt_val = noise();
`ifdef MD_SCHED_CANCEL_EN
        cancel = 1'b0;
`endif
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        while (scb.size() > 0 && scb[$].due > cyc) void'(scb.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        e.due = cyc + 1;
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        scb.push_back(e);
        if (busy_end > cyc) busy_end = cyc + 1;
        start = 1'b0;
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

`ifdef MD_SCHED_CANCEL_EN
    task automatic do_cancel();
        if (cyc < busy_end) begin
            while (scb.size() > 0 && scb[$].due > cyc) void'(scb.pop_back());
            m_hi     = p_hi;
            m_lo     = p_lo;
            busy_end = cyc + 1;
        end
        start  = 1'b0;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask
`endif

    // Monitor: mid-cycle, retire due entries and compare every visible output.
    always @(negedge clk) begin
        if (mon_en) begin
            while (scb.size() > 0 && scb[0].due < cyc) begin
                n_chk++;
                $display("FAIL sb_missed: entry due %0d not retired, now cycle %0d", scb[0].due, cyc);
                void'(scb.pop_front());
            end
            if (scb.size() > 0 && scb[0].due == cyc) begin
                mon_e = scb.pop_front();
                c_hi  = mon_e.hi;
                c_lo  = mon_e.lo;
            end
            chk("hi", hi, c_hi);
            chk("lo", lo, c_lo);
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_start && cyc < busy_end)});
            chk("md_stall", {31'd0, md_stall},
                {31'd0, (cyc >= busy_start && cyc < busy_end) ||
                        (start && md_op >= 3'd1 && md_op <= 3'd4)});
            if (start) chk("start_while_busy", {31'd0, busy}, 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle();
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        issue(MD_DIVU, 32'd7, 32'd0, 1'b0);
        wait_idle();
        chk("div0_hi", hi, 32'hFFFF_FFFF);
        chk("div0_lo", lo, 32'hFFFF_FFFD);

        issue(MD_MTHI, 32'h1234_5678, noise(), 1'b0);
        chk("mthi", hi, 32'h1234_5678);
        issue(MD_MTLO, 32'h9ABC_DEF0, noise(), 1'b0);
        chk("mtlo", lo, 32'h9ABC_DEF0);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);

        issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (3) idle_step();
        do_reset(2);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (12) idle_step();

`ifdef MD_SCHED_CANCEL_EN
        issue(MD_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
        issue(MD_MTLO, 32'h0000_5555, 32'd0, 1'b0);
        issue(MD_MULT, 32'd1000, 32'd1000, 1'b0);
        repeat (2) idle_step();
        do_cancel();
        chk("cxl_busy", {31'd0, busy}, 32'd0);
        chk("cxl_hi", hi, 32'h0000_AAAA);
        chk("cxl_lo", lo, 32'h0000_5555);
        repeat (NM + 2) idle_step();
`endif

        repeat (500) begin
            r = $urandom_range(0, 99);
            if (cyc < busy_end) begin
                if (r < 1) do_reset($urandom_range(1, 2));
`ifdef MD_SCHED_CANCEL_EN
                else if (r < 5) do_cancel();
`endif
                else idle_step();
            end else begin
                if (r < 2) begin
                    do_reset($urandom_range(1, 2));
                end else if (r < 65) begin
`ifdef MD_SCHED_CANCEL_EN
                    issue(3'($urandom_range(0, 6)), noise(), noise(), ($urandom_range(0, 9) == 0));
`else
                    issue(3'($urandom_range(0, 6)), noise(), noise(), 1'b0);
`endif
                end else begin
`ifdef MD_SCHED_CANCEL_EN
                    cancel = ($urandom_range(0, 3) == 0);
`endif
                    idle_step();
`ifdef MD_SCHED_CANCEL_EN
                    cancel = 1'b0;
`endif
                end
            end
        end
        wait_idle();
        idle_step();
        idle_step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
